// File: rtl/serial_mag_comparator.sv
// Bit-serial magnitude comparator: scans two WIDTH-bit operands MSB-first, one bit per clock,
// reporting gt/eq/lt in unsigned or two's-complement mode with a start/done handshake.
module serial_mag_comparator #(
  parameter int WIDTH      = 8,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
  output logic             busy,
  output logic             done,
  output logic             gt,
  output logic             eq,
  output logic             lt
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] TOP_IDX = IW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic            sgn_q;
  logic [IW-1:0]   idx_q;
  logic            diff_seen_q, diff_gt_q;
  logic            busy_q, done_q, gt_q, eq_q, lt_q;

  logic bit_diff, bit_gt, res_gt_d, res_eq_d;

  always_comb begin
    bit_diff = a_q[idx_q] ^ b_q[idx_q];
    // The sign bit carries negative weight, so a set bit there means the smaller value.
    bit_gt   = a_q[idx_q] ^ (sgn_q && (idx_q == TOP_IDX));
    res_gt_d = diff_seen_q ? diff_gt_q : bit_gt;
    res_eq_d = !diff_seen_q && !bit_diff;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sgn_q       <= 1'b0;
      idx_q       <= '0;
      diff_seen_q <= 1'b0;
      diff_gt_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      gt_q        <= 1'b0;
      eq_q        <= 1'b0;
      lt_q        <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            a_q         <= a;
            b_q         <= b;
            sgn_q       <= signed_mode;
            idx_q       <= TOP_IDX;
            diff_seen_q <= 1'b0;
            diff_gt_q   <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= SCAN;
          end
        end
        SCAN: begin
          if ((EARLY_EXIT && bit_diff) || (idx_q == '0)) begin
            gt_q    <= !res_eq_d && res_gt_d;
            eq_q    <= res_eq_d;
            lt_q    <= !res_eq_d && !res_gt_d;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            // Only the most significant difference is kept; later bits cannot override it.
            if (!diff_seen_q && bit_diff) begin
              diff_seen_q <= 1'b1;
              diff_gt_q   <= bit_gt;
            end
            idx_q <= idx_q - IW'(1);
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign gt   = gt_q;
  assign eq   = eq_q;
  assign lt   = lt_q;

endmodule

// File: doc/serial_mag_comparator.md
Name: serial_mag_comparator

Overview:
- Parametrised, multi-cycle successor to the single-bit comparator.
- Compares two WIDTH-bit operands MSB-first, one bit per clock, and reports greater-than, equal and less-than.
- Supports unsigned and two's-complement modes, selected per operation.
- Start/done handshake. Optional early termination at the first differing bit.
- Used where area matters more than latency, e.g. threshold checks in slow control paths.

Parameters:
- WIDTH, 8: operand width in bits. Legal values are 1 and above.
- EARLY_EXIT, 1: 1 = finish at the first differing bit; 0 = always scan all WIDTH bits (fixed latency).

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- reset, input, 1: synchronous, active-high reset.
- start, input, 1: request a compare; accepted only when busy=0.
- a, input, WIDTH: operand A; sampled on the accepting edge.
- b, input, WIDTH: operand B; sampled on the accepting edge.
- signed_mode, input, 1: 1 = two's-complement compare; sampled with the operands.
- busy, output, 1: high in the SCAN and DONE states.
- done, output, 1: one-cycle pulse; results are valid from this cycle onward.
- gt, output, 1: a > b.
- eq, output, 1: a == b.
- lt, output, 1: a < b.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values:
  - State = IDLE.
  - busy, done, gt, eq, lt = 0.
  - Internal operand registers, index and mode registers = 0.
- States: IDLE, SCAN, DONE.
- IDLE:
  - busy=0.
  - start=1 at an edge latches a, b and signed_mode, sets idx=WIDTH-1 and moves to SCAN.
- SCAN (one cycle per bit), comparing latched bits A[idx] and B[idx]:
  - Unsigned, or idx<WIDTH-1: A=1/B=0 means a>b; A=0/B=1 means a<b.
  - Signed and idx==WIDTH-1 (sign bit): the sense is inverted. A=1/B=0 means a<b; A=0/B=1 means a>b.
  - Only the first (most significant) differing bit decides the result. Later bits never override it.
  - EARLY_EXIT=1 and bits differ: the result is decided; go to DONE.
  - EARLY_EXIT=0: record the first difference and continue. Go to DONE after the idx==0 cycle.
  - idx==0 with no difference seen: the result is eq; go to DONE.
  - Otherwise decrement idx. No underflow is possible.
- DONE:
  - done=1 and busy=1 for exactly one cycle.
  - gt/eq/lt are loaded on entry to DONE. Exactly one of them is high.
  - Next state is IDLE.
- Result hold:
  - gt/eq/lt hold their value until the next DONE entry.
  - An accepted start does not clear them.
  - After reset all three stay 0 until the first DONE.
- Latency, measured from the edge that accepts start to the cycle in which done is high:
  - EARLY_EXIT=0: always WIDTH+1 cycles.
  - EARLY_EXIT=1: WIDTH-p+1 cycles, where p is the index of the most significant differing bit.
  - EARLY_EXIT=1, equal operands: WIDTH+1 cycles.
- Ignored inputs:
  - start while busy=1 (SCAN or DONE) is ignored; there is no queueing.
  - Changes on a, b or signed_mode after acceptance have no effect.
- Back-to-back operation: the earliest new accept is the IDLE cycle after DONE. Throughput is at most one compare per latency+1 cycles.
- Reset mid-operation:
  - Returns to IDLE on the next edge.
  - No done pulse is produced.
  - Results are cleared to 0.
  - reset has priority over start.
- WIDTH=1:
  - One SCAN cycle.
  - In signed mode, bit value 1 means -1, so 1 < 0.

Test Plan:
- Equal operands: WIDTH=8, EARLY_EXIT=1, unsigned, a=0x5A, b=0x5A -> done 9 cycles after accept; eq=1, gt=0, lt=0.
- Early exit: EARLY_EXIT=1, unsigned, a=0x80, b=0x7F -> done 2 cycles after accept; gt=1.
- Signed mode: signed, a=0x80 (-128), b=0x7F (127) -> lt=1. Then signed, a=0x01, b=0xFF (-1) -> gt=1.
- Fixed latency: EARLY_EXIT=0, unsigned, a=0x80, b=0x7F -> done exactly 9 cycles after accept; gt=1. Check that later bits (1 vs 0 in bits 6..0) do not flip the result.
- Handshake: accept a=0x10, b=0x20. Pulse start with a=0xFF, b=0x00 during SCAN and again during DONE -> both pulses ignored; result lt=1; busy returns to 0 after one DONE cycle. The next start is accepted in IDLE.
- Reset mid-scan: accept a=0x01, b=0x00 with EARLY_EXIT=0, assert reset at the 4th SCAN cycle -> IDLE next edge; no done pulse; gt/eq/lt=0; a fresh compare afterwards completes normally.
